// File: rtl/uop_sequencer_pkg.sv
// Shared definitions for the micro-op sequencer: default uop width, bundle count
// field width and the count normalisation used when a bundle is captured.
package uop_sequencer_pkg;

  localparam int UOP_W_DEF = 20;
  localparam int CNT_W     = 2;

  // A count of 3 is not a legal bundle size; it issues as a full 3-uop bundle.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt == 2'd3) ? 2'd2 : cnt;
  endfunction

endpackage

// File: rtl/uop_sequencer_bundle_fifo.sv
// Register FIFO of decoded bundles with flush. Exposes the head entry body and the
// tag field of the entry behind the head so the issuer can preload its step counter.
module bundle_fifo
  import uop_sequencer_pkg::*;
#(
  parameter int W     = 62,
  parameter int DEPTH = 2,
  parameter int TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-TAG_W-1:0]         head_body,
  output logic [TAG_W-1:0]           next_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign empty     = (occupancy == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_body = mem[rd_ptr][W-TAG_W-1:0];
  assign next_tag  = mem[rd_ptr + AW'(1)][W-1:W-TAG_W];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Drop everything: read side catches up with write side.
      rd_ptr    <= wr_ptr;
      occupancy <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// Buffers decoded uop bundles and issues them one uop per cycle (uop_2, uop_1,
// uop_0) to execute over valid/ready; drives decoder back-pressure and flush drop.
module uop_sequencer
  import uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  output logic             feed_req,
  input  logic             feed_ack,
  input  logic [UOP_W-1:0] uop_0,
  input  logic [UOP_W-1:0] uop_1,
  input  logic [UOP_W-1:0] uop_2,
  input  logic [1:0]       uop_count,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [UOP_W-1:0] ex_uop,
  output logic             ex_last,
  output logic             idle
);

  localparam int BW = 3*UOP_W + CNT_W;
  localparam int OW = $clog2(DEPTH) + 1;

  logic [BW-1:0]       wr_bundle;
  logic [3*UOP_W-1:0]  head_uops;
  logic [CNT_W-1:0]    next_tag;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    next_cnt;
  logic [CNT_W-1:0]    step;
  logic [OW-1:0]       occupancy;
  logic [UOP_W-1:0]    head_uop;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                accept;

  // Bundle layout: count on top so the FIFO can peek it for the entry behind head.
  assign in_cnt    = clamp_cnt(uop_count);
  assign wr_bundle = {in_cnt, uop_2, uop_1, uop_0};

  assign feed_req = ~full;
  assign push     = feed_ack & feed_req & ~flush;
  assign ex_valid = ~empty & ~flush;
  assign accept   = ex_valid & ex_ready;
  assign pop      = accept & (step == '0);
  assign idle     = empty;

  bundle_fifo #(
    .W     (BW),
    .DEPTH (DEPTH),
    .TAG_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .a_rst     (a_rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wr_data   (wr_bundle),
    .head_body (head_uops),
    .next_tag  (next_tag),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_comb begin
    head_uop = head_uops[UOP_W-1:0];
    case (step)
      2'd1:    head_uop = head_uops[2*UOP_W-1:UOP_W];
      2'd2:    head_uop = head_uops[3*UOP_W-1:2*UOP_W];
      default: head_uop = head_uops[UOP_W-1:0];
    endcase
  end

  assign ex_uop  = ex_valid ? head_uop : '0;
  assign ex_last = ex_valid & (step == '0);

  // Count of the bundle that becomes head after a pop: the one behind it if present,
  // otherwise the bundle being written this same cycle.
  always_comb begin
    next_cnt = '0;
    if (occupancy > OW'(1)) next_cnt = next_tag;
    else if (push)          next_cnt = in_cnt;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      step <= '0;
    end else if (flush) begin
      step <= '0;
    end else if (pop) begin
      step <= next_cnt;
    end else if (push && empty) begin
      step <= in_cnt;
    end else if (accept) begin
      step <= step - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: directed scenarios plus randomized traffic
// against a bundle-queue reference model.
module tb_uop_sequencer;

  localparam int UOP_W = 20;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             a_rst;
  logic             flush;
  logic             feed_req;
  logic             feed_ack;
  logic [UOP_W-1:0] uop_0;
  logic [UOP_W-1:0] uop_1;
  logic [UOP_W-1:0] uop_2;
  logic [1:0]       uop_count;
  logic             ex_valid;
  logic             ex_ready;
  logic [UOP_W-1:0] ex_uop;
  logic             ex_last;
  logic             idle;

  int checks   = 0;
  int failures = 0;

  uop_sequencer #(.UOP_W(UOP_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .flush     (flush),
    .feed_req  (feed_req),
    .feed_ack  (feed_ack),
    .uop_0     (uop_0),
    .uop_1     (uop_1),
    .uop_2     (uop_2),
    .uop_count (uop_count),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_uop    (ex_uop),
    .ex_last   (ex_last),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  // Reference model: queue of bundles, each an issue-ordered list of uops.
  typedef struct {
    logic [UOP_W-1:0] u [3];
    int               n;
  } bun_t;

  bun_t q[$];
  int   pos = 0;

  function automatic bit m_valid();  return (q.size() > 0) && !flush; endfunction
  function automatic bit m_feed();   return q.size() < DEPTH;         endfunction
  function automatic bit m_idle();   return q.size() == 0;            endfunction
  function automatic logic [UOP_W-1:0] m_uop(); return q[0].u[pos];   endfunction
  function automatic bit m_last();   return pos == q[0].n - 1;        endfunction

  task automatic drive(input bit fa, input bit rdy, input bit fl, input logic [1:0] cnt,
                       input logic [UOP_W-1:0] u2, input logic [UOP_W-1:0] u1,
                       input logic [UOP_W-1:0] u0);
    feed_ack = fa; ex_ready = rdy; flush = fl; uop_count = cnt;
    uop_2 = u2; uop_1 = u1; uop_0 = u0;
  endtask

  // Advance one clock and apply the same cycle's effects to the model.
  task automatic tick();
    bit   acc;
    bit   wr;
    bun_t b;
    acc = (q.size() > 0) && !flush && ex_ready;
    wr  = feed_ack && (q.size() < DEPTH) && !flush;
    b.n = (uop_count >= 2) ? 3 : int'(uop_count) + 1;
    if (b.n == 3)      begin b.u[0] = uop_2; b.u[1] = uop_1; b.u[2] = uop_0; end
    else if (b.n == 2) begin b.u[0] = uop_1; b.u[1] = uop_0; b.u[2] = '0;    end
    else               begin b.u[0] = uop_0; b.u[1] = '0;    b.u[2] = '0;    end
    @(posedge clk);
    if (flush) begin
      q.delete();
      pos = 0;
    end else begin
      if (acc) begin
        pos++;
        if (pos == q[0].n) begin
          void'(q.pop_front());
          pos = 0;
        end
      end
      if (wr) q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (feed_req !== 1'b1) begin failures++; $display("FAIL reset_feed_req got=%b exp=1", feed_req); end
    checks++; if (ex_uop !== '0) begin failures++; $display("FAIL reset_uop got=%h exp=0", ex_uop); end
    @(negedge clk);
    a_rst = 1'b1;
    // Reset while a 3-uop bundle is partway through issue.
    drive(1, 0, 0, 2, 20'h1AAAA, 20'h1BBBB, 20'h1CCCC);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    #2 a_rst = 1'b0;
    q.delete(); pos = 0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", ex_valid); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
    checks++; if (feed_req !== 1'b1) begin failures++; $display("FAIL midrst_feed_req got=%b exp=1", feed_req); end
    checks++; if (ex_last !== 1'b0) begin failures++; $display("FAIL midrst_last got=%b exp=0", ex_last); end
    @(posedge clk); #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL midrst_hold_valid got=%b exp=0", ex_valid); end
    @(negedge clk);
    a_rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL postrst_valid got=%b exp=0", ex_valid); end
    tick();
  endtask

  task automatic test_single();
    drive(1, 1, 0, 0, 0, 0, 20'h00123);
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%b exp=0", ex_valid); end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_uop !== 20'h00123) begin failures++; $display("FAIL single_uop got=%h exp=00123", ex_uop); end
    checks++; if (ex_last !== 1'b1) begin failures++; $display("FAIL single_last got=%b exp=1", ex_last); end
    tick();
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL single_done got=%b exp=0", ex_valid); end
  endtask

  task automatic test_ready_toggle();
    bit               rdy   [4] = '{1, 0, 1, 1};
    logic [UOP_W-1:0] exp_u [4] = '{20'hAAAAA, 20'hBBBBB, 20'hBBBBB, 20'hCCCCC};
    bit               exp_l [4] = '{0, 0, 0, 1};
    drive(1, 0, 0, 2, 20'hAAAAA, 20'hBBBBB, 20'hCCCCC);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, rdy[i], 0, 0, 0, 0, 0);
      #1;
      checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL toggle_valid[%0d] got=%b exp=1", i, ex_valid); end
      checks++; if (ex_uop !== exp_u[i]) begin failures++; $display("FAIL toggle_uop[%0d] got=%h exp=%h", i, ex_uop, exp_u[i]); end
      checks++; if (ex_last !== exp_l[i]) begin failures++; $display("FAIL toggle_last[%0d] got=%b exp=%b", i, ex_last, exp_l[i]); end
      tick();
    end
    #1;
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL toggle_idle got=%b exp=1", idle); end
  endtask

  task automatic test_back_to_back();
    logic [UOP_W-1:0] exp_u [3] = '{20'h0A001, 20'h0A000, 20'h0B000};
    bit               exp_l [3] = '{0, 1, 1};
    bit               exp_f [3] = '{0, 0, 1};
    drive(1, 0, 0, 1, 0, 20'h0A001, 20'h0A000);
    tick();
    drive(1, 0, 0, 0, 0, 0, 20'h0B000);
    tick();
    drive(1, 0, 0, 2, 20'h0DEAD, 20'h0DEAD, 20'h0DEAD);
    #1;
    checks++; if (feed_req !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", feed_req); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      #1;
      checks++; if (ex_uop !== exp_u[i]) begin failures++; $display("FAIL b2b_uop[%0d] got=%h exp=%h", i, ex_uop, exp_u[i]); end
      checks++; if (ex_last !== exp_l[i]) begin failures++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, ex_last, exp_l[i]); end
      checks++; if (feed_req !== exp_f[i]) begin failures++; $display("FAIL b2b_feed[%0d] got=%b exp=%b", i, feed_req, exp_f[i]); end
      tick();
    end
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL b2b_dropped_issued got=%b exp=0", ex_valid); end
  endtask

  task automatic test_count3();
    logic [UOP_W-1:0] seen [$];
    drive(1, 1, 0, 3, 20'h30002, 20'h30001, 20'h30000);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      #1;
      if (ex_valid === 1'b1) seen.push_back(ex_uop);
      tick();
    end
    checks++; if (seen.size() != 3) begin failures++; $display("FAIL cnt3_num got=%0d exp=3", seen.size()); end
    if (seen.size() == 3) begin
      checks++;
      if (seen[0] !== 20'h30002 || seen[1] !== 20'h30001 || seen[2] !== 20'h30000) begin
        failures++; $display("FAIL cnt3_order got=%h,%h,%h exp=30002,30001,30000", seen[0], seen[1], seen[2]);
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 2, 20'h11111, 20'h22222, 20'h33333);
    tick();
    drive(1, 0, 0, 2, 20'h44444, 20'h55555, 20'h66666);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (ex_uop !== 20'h11111) begin failures++; $display("FAIL flush_pre_uop got=%h exp=11111", ex_uop); end
    tick();
    drive(1, 1, 1, 0, 0, 0, 20'h77777);
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_cycle_valid got=%b exp=0", ex_valid); end
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_next_valid got=%b exp=0", ex_valid); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_idle got=%b exp=1", idle); end
    checks++; if (feed_req !== 1'b1) begin failures++; $display("FAIL flush_feed got=%b exp=1", feed_req); end
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_leak[%0d] got=%b uop=%h exp=0", i, ex_valid, ex_uop); end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0),
            2'($urandom_range(0, 3)), 20'($urandom), 20'($urandom), 20'($urandom));
      #1;
      checks++; if (feed_req !== m_feed()) begin failures++; $display("FAIL rnd_feed c=%0d got=%b exp=%b", c, feed_req, m_feed()); end
      checks++; if (ex_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ex_valid, m_valid()); end
      checks++; if (idle !== m_idle()) begin failures++; $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, idle, m_idle()); end
      if (m_valid()) begin
        checks++; if (ex_uop !== m_uop()) begin failures++; $display("FAIL rnd_uop c=%0d got=%h exp=%h", c, ex_uop, m_uop()); end
        checks++; if (ex_last !== m_last()) begin failures++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, ex_last, m_last()); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ready_toggle();
    test_back_to_back();
    test_count3();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
